// File: rtl/spi_mult_slave.sv
// rtl/spi_mult_slave.sv - SPI slave that multiplies two received operands and returns the product next frame
module spi_mult_slave #(
    parameter int W    = 4,
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           SCK,
    input  logic           SSEL,
    input  logic           MOSI,
    output logic           MISO,
    output logic           MISO_OE,
    output logic [2*W-1:0] PROD,
    output logic           PROD_VALID,
    output logic           FRAME_ERR
);

    localparam int N  = 2 * W;
    localparam int CW = $clog2(N + 1);

    // Sample on rising SCK when CPOL==CPHA, otherwise on falling SCK.
    localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    logic sck_meta, sck_sync, sck_prev;
    logic ssel_meta, ssel_sync, ssel_prev;
    logic mosi_meta, mosi_sync;
    logic [1:0] prime;
    logic armed;

    state_t         state;
    logic [CW-1:0]  bit_cnt;
    logic [N-1:0]   rx;
    logic [N-1:0]   tx_hold;
    logic [N-1:0]   tx_shift;
    logic [N-1:0]   prod_q;
    logic           prod_valid_q;
    logic           frame_err_q;
    logic           miso_q;
    logic           first_shift;
    logic           calc_pending;

    logic sck_rise, sck_fall, sample_edge, shift_edge;
    logic ssel_fall, ssel_rise;
    logic [N-1:0] a_ext, b_ext, product;

    // Two-flop synchronisers plus one history flop per input for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_meta  <= CPOL;
            sck_sync  <= CPOL;
            sck_prev  <= CPOL;
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
            ssel_prev <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sck_meta  <= SCK;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            ssel_meta <= SSEL;
            ssel_sync <= ssel_meta;
            ssel_prev <= ssel_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    // After reset a frame may only start once SSEL has genuinely been seen high,
    // so a slave select still held low across reset release is not taken as a new frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            prime <= {prime[0], 1'b1};
            if (prime[1] && ssel_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise    = sck_sync & ~sck_prev;
    assign sck_fall    = ~sck_sync & sck_prev;
    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
    assign ssel_fall   = ssel_prev & ~ssel_sync & armed;
    assign ssel_rise   = ~ssel_prev & ssel_sync;

    assign a_ext   = {{W{1'b0}}, rx[N-1:W]};
    assign b_ext   = {{W{1'b0}}, rx[W-1:0]};
    assign product = a_ext * b_ext;

    // Frame state machine: receive 2W bits, multiply, and stage the product for the next frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            rx           <= '0;
            tx_hold      <= '0;
            tx_shift     <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            first_shift  <= 1'b0;
            calc_pending <= 1'b0;
        end else begin
            prod_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            calc_pending <= 1'b0;

            if (calc_pending) begin
                prod_q       <= product;
                tx_hold      <= product;
                prod_valid_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ssel_fall && !ssel_rise) begin
                        state       <= RECV;
                        bit_cnt     <= '0;
                        tx_shift    <= tx_hold;
                        miso_q      <= tx_hold[N-1];
                        first_shift <= 1'b1;
                    end
                end
                RECV: begin
                    if (ssel_rise) begin
                        state <= IDLE;
                        if (bit_cnt != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sample_edge) begin
                        rx      <= {rx[N-2:0], mosi_sync};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(N - 1)) begin
                            state        <= DONE;
                            calc_pending <= 1'b1;
                            miso_q       <= 1'b0;
                        end
                    end else if (shift_edge) begin
                        first_shift <= 1'b0;
                        if (!(CPHA && first_shift)) begin
                            tx_shift <= {tx_shift[N-2:0], 1'b0};
                            miso_q   <= tx_shift[N-2];
                        end
                    end
                end
                DONE: begin
                    miso_q <= 1'b0;
                    if (ssel_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MISO       = miso_q;
    assign MISO_OE    = ~ssel_sync;
    assign PROD       = prod_q;
    assign PROD_VALID = prod_valid_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: doc/spi_mult_slave.md
SPI_MULT_SLAVE -- requirements
Module: spi_mult_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock and reset ports SHALL be named CLK and RST_N.
REQ-002 Parameter W, default 4, SHALL set the operand width in bits; legal range 2..16.
REQ-003 Parameter CPOL, default 0, SHALL set the SCK idle level.
REQ-004 Parameter CPHA, default 0, SHALL set the SPI phase: 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-005 Port CLK, input, 1 bit, SHALL be the system clock; its frequency SHALL be at least 8x the SCK frequency.
REQ-006 Port RST_N, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port SCK, input, 1 bit, SHALL be the SPI serial clock, asynchronous to CLK.
REQ-008 Port SSEL, input, 1 bit, SHALL be the active-low slave select, asynchronous to CLK.
REQ-009 Port MOSI, input, 1 bit, SHALL be the master-to-slave serial data.
REQ-010 Port MISO, output, 1 bit, SHALL be the slave-to-master serial data.
REQ-011 Port MISO_OE, output, 1 bit, SHALL be high exactly while synchronised SSEL is low.
REQ-012 Port PROD, output, 2W bits, SHALL hold the last completed product.
REQ-013 Port PROD_VALID, output, 1 bit, SHALL be a 1-CLK pulse marking a PROD update.
REQ-014 Port FRAME_ERR, output, 1 bit, SHALL be a 1-CLK pulse marking an aborted frame.

Function
REQ-015 SCK, SSEL and MOSI SHALL each pass through a 2-flop synchroniser; all edges SHALL be detected on the synchronised signals in the CLK domain.
REQ-016 The sample edge SHALL be SCK rising when CPOL==CPHA and SCK falling otherwise; the shift edge SHALL be the opposite edge.
REQ-017 The state machine SHALL have states IDLE, RECV and DONE.
REQ-018 IDLE -> RECV on SSEL falling: bit counter cleared, MISO drives TX[2W-1].
REQ-019 In RECV, each sample edge SHALL shift MOSI into RX and increment the bit counter (MSB first); the first W bits SHALL be operand A and the next W bits operand B.
REQ-020 In RECV, each shift edge SHALL left-shift TX and present the new TX[2W-1] on MISO.
REQ-021 When CPHA=1, the first shift edge of a frame SHALL NOT shift TX.
REQ-022 On the 2W-th sample edge, the block SHALL go RECV -> DONE.
REQ-023 In DONE, the block SHALL compute PROD = A*B (unsigned, full 2W-bit result, no truncation), load TX with the product, and pulse PROD_VALID, all in the CLK cycle after the transition into DONE.
REQ-024 Sample edges in DONE SHALL be ignored, and MISO SHALL drive 0 after the last TX bit.
REQ-025 DONE -> IDLE on SSEL rising, with no FRAME_ERR.
REQ-026 RECV -> IDLE on SSEL rising with bit counter in 1..2W-1: FRAME_ERR pulse; PROD, PROD_VALID and TX unchanged, so the previous result is re-sent next frame.
REQ-027 RECV -> IDLE on SSEL rising with counter 0: silent, with no error pulse.
REQ-028 When SSEL falling and SSEL rising are detected in the same CLK cycle, the block SHALL treat them as a zero-bit frame: no pulse, state IDLE.
REQ-029 The product of frame n SHALL be shifted out on MISO during frame n+1, MSB first.
REQ-030 Before the first valid frame after reset, the block SHALL shift out zeros.
REQ-031 PROD_VALID SHALL assert no later than 4 CLK after the raw SCK edge carrying bit 2W.
REQ-032 SCK edges while SSEL is high SHALL be ignored.

Reset
REQ-033 While RST_N is low, the block SHALL hold state IDLE, bit counter 0, RX=0, TX=0, PROD=0, PROD_VALID=0, FRAME_ERR=0, MISO=0 and MISO_OE=0, and clear all synchroniser flops to the idle levels (SCK=CPOL, SSEL=1, MOSI=0).
REQ-034 Reset asserted mid-frame SHALL abort the frame with no FRAME_ERR; after release, the block SHALL wait for a fresh SSEL falling edge even if SSEL is already low.

Verification
REQ-035 W=4, mode 0: frame 1011_0111 (A=0xB, B=0x7) -> PROD=0x4D with one PROD_VALID pulse; next frame MISO = 0,1,0,0,1,1,0,1.
REQ-036 W=4: A=0xF, B=0xF -> PROD=0xE1; A=0x0, B=0x9 -> PROD=0x00 with PROD_VALID still pulsed.
REQ-037 W=4: prior PROD=0x4D, then a 5-bit frame -> one FRAME_ERR pulse, PROD stays 0x4D, and the next frame re-sends 0x4D.
REQ-038 W=4, CPOL=1, CPHA=1: A=0x3, B=0x5 -> PROD=0x0F, and MISO bits align to trailing edges in the following frame.
REQ-039 W=4: RST_N pulsed low after 3 bits -> all outputs 0 and no FRAME_ERR; a subsequent full frame A=0x2, B=0x6 -> PROD=0x0C.
REQ-040 W=8: 20-bit frame A=0xC8, B=0x96, then 4 extra bits -> PROD=0x7530, with the extra bits ignored and MISO=0 during the extras.
